// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped read-only instruction cache; zero-latency hits,
//            whole-line burst refill on a miss. Optional hit/miss counters are
//            built when ICACHE_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;  // burst length encoded as beats-1

  localparam msize_t MSIZE4 = 3'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module icache
  import icache_pkg::*;
#(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WORD_BITS  = OFFSET_BITS - 2;
  localparam int LINE_WORDS = 2 ** WORD_BITS;
  localparam int LINES      = 2 ** INDEX_BITS;
  localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0] state_q, state_d;

  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [TAG_BITS-1:0] tag_d  [LINES];
  logic [31:0]         data_q [LINES][LINE_WORDS];
  logic [31:0]         data_d [LINES][LINE_WORDS];

  logic [31:0]          miss_addr_q, miss_addr_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [WORD_BITS-1:0]  req_word;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic                  hit;
  logic                  hs_hit;
  logic                  go_refill;
  logic                  beat;
  logic                  unused_addr_bits;

  assign req_tag  = ireq.addr[31 -: TAG_BITS];
  assign req_idx  = ireq.addr[OFFSET_BITS +: INDEX_BITS];
  assign req_word = ireq.addr[2 +: WORD_BITS];
  assign miss_tag = miss_addr_q[31 -: TAG_BITS];
  assign miss_idx = miss_addr_q[OFFSET_BITS +: INDEX_BITS];

  assign unused_addr_bits = ^ireq.addr[1:0];

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hs_hit    = (state_q == IDLE) && ireq.valid && hit;
  assign go_refill = (state_q == IDLE) && ireq.valid && !hit;
  assign beat      = (state_q == REFILL) && cresp.ready;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ireq.valid && !hit) state_d = REFILL;
      REFILL:  if (cresp.ready && cresp.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iresp = '0;
    creq  = '0;
    case (state_q)
      IDLE: begin
        if (hs_hit) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = data_q[req_idx][req_word];
        end
      end
      REFILL: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = MSIZE4;
        creq.addr     = miss_addr_q;
        creq.strobe   = '0;
        creq.data     = '0;
        creq.len      = mlen_t'(LINE_WORDS - 1);
      end
      default: begin
        iresp = '0;
        creq  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- storage
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    miss_addr_d = miss_addr_q;
    cnt_d       = cnt_q;

    // The victim is invalidated up front so a half-written line never hits.
    if (go_refill) begin
      miss_addr_d      = {ireq.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      cnt_d            = '0;
      valid_d[req_idx] = 1'b0;
    end

    if (beat) begin
      data_d[miss_idx][cnt_q] = cresp.data;
      cnt_d                   = cnt_q + WORD_BITS'(1);
      if (cresp.last) begin
        tag_d[miss_idx]   = miss_tag;
        valid_d[miss_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q       <= tag_d;
    data_q      <= data_d;
    miss_addr_q <= miss_addr_d;
  end

  // ---------------------------------------------------------------- counters
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hs_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (go_refill && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  // Counters not built; hit/miss events only steer the FSM and storage.
`endif

endmodule

`default_nettype wire
